// File: rtl/sccb_pkg.sv
// sccb_pkg: shared FSM states, bus event encoding and ACK bit levels for the SCCB register target.
package sccb_pkg;
   typedef enum logic [3:0] {
      IDLE, DEV, ACK_DEV, SUB_HI, ACK_HI, SUB_LO, ACK_LO, WDATA, ACK_W, RDATA, RACK, IGNORE
   } state_t;
   typedef enum logic [1:0] {EV_NONE, EV_START, EV_STOP} event_t;
   localparam logic BIT_ACK = 1'b0;
   localparam logic BIT_NACK = 1'b1;
   function automatic logic is_ack(input state_t s);
      return s inside {ACK_DEV, ACK_HI, ACK_LO, ACK_W};
   endfunction
endpackage

// File: rtl/sccb_line_filter.sv
// sccb_line_filter: synchronizes one open-drain pin, debounces it over FILTER_LEN samples
// and emits single-cycle rise/fall pulses of the filtered level.
module sccb_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [1:0] sync;
   logic [2:0] cnt;
   logic prev;
   // idle bus level is high, so reset to 1 to avoid phantom edges after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= 2'b11;
         cnt <= '0;
         level <= 1'b1;
         prev <= 1'b1;
      end else begin
         sync <= {sync[0], pin};
         prev <= level;
         if (sync[1] == level) cnt <= '0;
         else if (cnt == 3'(FILTER_LEN - 1)) begin
            level <= sync[1];
            cnt <= '0;
         end else cnt <= cnt + 3'd1;
      end
   end
   assign rise = level & ~prev;
   assign fall = ~level & prev;
endmodule

// File: rtl/sccb_reg_slave.sv
// sccb_reg_slave: SCCB/I2C target with 16-bit register pointer, 8-bit data and auto-increment.
// Optional SCL stretching around read-data fetches is enabled by defining SCCB_STRETCH_EN.
module sccb_reg_slave
   import sccb_pkg::*;
#(
   parameter logic [6:0] DEVICE_ADDRESS = 7'h3C,
   parameter int FILTER_LEN = 3
) (
   input  logic        i_sysclk,
   input  logic        i_arst,
   input  logic        i_scl,
   output logic        o_scl_oe,
   input  logic        i_sda,
   output logic        o_sda_oe,
   output logic [15:0] o_reg_addr,
   output logic [7:0]  o_reg_wdata,
   output logic        o_reg_we,
   output logic        o_reg_re,
   input  logic [7:0]  i_reg_rdata,
   output logic        o_busy
);
   logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
   logic [7:0] shift, byte_in;
   logic [3:0] bit_cnt;
   logic ack_on, rd_pend, rw, rx, last_bit, addr_match;
   state_t state, next;
   event_t ev;

   sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
      .clk(i_sysclk), .rst(i_arst), .pin(i_scl), .level(scl), .rise(scl_rise), .fall(scl_fall)
   );
   sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
      .clk(i_sysclk), .rst(i_arst), .pin(i_sda), .level(sda), .rise(sda_rise), .fall(sda_fall)
   );

   assign ev = (sda_fall && scl) ? EV_START : (sda_rise && scl) ? EV_STOP : EV_NONE;
   assign rx = state inside {DEV, SUB_HI, SUB_LO, WDATA};
   assign byte_in = {shift[6:0], sda};
   assign last_bit = rx && scl_rise && bit_cnt == 4'd7;
   assign addr_match = byte_in[7:1] == DEVICE_ADDRESS;

   always_ff @(posedge i_sysclk or posedge i_arst) begin
      if (i_arst) state <= IDLE;
      else state <= next;
   end

   always_comb begin
      next = state;
      if (ev == EV_STOP) next = IDLE;
      else if (ev == EV_START) next = DEV;
      else begin
         case (state)
            DEV:     if (last_bit) next = addr_match ? ACK_DEV : IGNORE;
            SUB_HI:  if (last_bit) next = ACK_HI;
            SUB_LO:  if (last_bit) next = ACK_LO;
            WDATA:   if (last_bit) next = ACK_W;
            ACK_DEV: if (scl_fall && ack_on) next = rw ? RDATA : SUB_HI;
            ACK_HI:  if (scl_fall && ack_on) next = SUB_LO;
            ACK_LO:  if (scl_fall && ack_on) next = WDATA;
            ACK_W:   if (scl_fall && ack_on) next = WDATA;
            RDATA:   if (scl_fall && bit_cnt == 4'd8) next = RACK;
            RACK:    if (scl_rise && sda == BIT_NACK) next = IGNORE;
                     else if (scl_fall) next = RDATA;
            default: ;
         endcase
      end
   end

   always_comb o_sda_oe = is_ack(state) ? ack_on : (state == RDATA) && !shift[7];

   always_ff @(posedge i_sysclk or posedge i_arst) begin
      if (i_arst) begin
         shift <= '0;
         bit_cnt <= '0;
         ack_on <= 1'b0;
         rd_pend <= 1'b0;
         rw <= 1'b0;
         o_reg_addr <= '0;
         o_reg_wdata <= '0;
         o_reg_we <= 1'b0;
         o_reg_re <= 1'b0;
         o_busy <= 1'b0;
      end else begin
         o_reg_we <= 1'b0;
         o_reg_re <= 1'b0;
         rd_pend <= o_reg_re;
         if (ev != EV_NONE) begin
            bit_cnt <= '0;
            ack_on <= 1'b0;
            if (ev == EV_STOP) o_busy <= 1'b0;
         end else begin
            if (rx && scl_rise) begin
               shift <= byte_in;
               bit_cnt <= bit_cnt + 4'd1;
            end
            if (last_bit) begin
               bit_cnt <= '0;
               if (state == DEV) begin
                  rw <= sda;
                  if (addr_match) begin
                     o_busy <= 1'b1;
                     o_reg_re <= sda;
                  end
               end
               if (state == SUB_HI) o_reg_addr[15:8] <= byte_in;
               if (state == SUB_LO) o_reg_addr[7:0] <= byte_in;
               if (state == WDATA) begin
                  o_reg_wdata <= byte_in;
                  o_reg_we <= 1'b1;
               end
            end
            if (is_ack(state) && scl_fall) begin
               ack_on <= !ack_on;
               if (ack_on && state == ACK_W) o_reg_addr <= o_reg_addr + 16'd1;
            end
            if (state == RDATA && scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (state == RDATA && scl_fall) begin
               shift <= {shift[6:0], 1'b0};
               if (bit_cnt == 4'd8) bit_cnt <= '0;
            end
            if (state == RACK && scl_rise && sda == BIT_ACK) begin
               o_reg_addr <= o_reg_addr + 16'd1;
               o_reg_re <= 1'b1;
            end
         end
         if (rd_pend) shift <= i_reg_rdata;
      end
   end

`ifdef SCCB_STRETCH_EN
   logic [1:0] hold;
   logic stretch;
   // keep SCL low from the fall that opens a read byte until the fetched byte is in the shifter
   always_ff @(posedge i_sysclk or posedge i_arst) begin
      if (i_arst) begin
         stretch <= 1'b0;
         hold <= '0;
      end else if (scl_fall && next == RDATA && state != RDATA) begin
         stretch <= 1'b1;
         hold <= 2'd2;
      end else if (stretch) begin
         if (hold != 2'd0) hold <= hold - 2'd1;
         else if (!rd_pend && !o_reg_re) stretch <= 1'b0;
      end
   end
   assign o_scl_oe = stretch;
`else
   assign o_scl_oe = 1'b0;
`endif
endmodule

// File: doc/sccb_reg_slave.md
Name: sccb_reg_slave

Overview:
I2C/SCCB target (responder) that emulates a camera-style register space. It answers a configuration master at one 7-bit device address, using 16-bit register sub-addresses and 8-bit data with auto-increment. It exposes a synchronous register-file port so the bench or an on-chip shadow register file can capture configuration writes and serve reads. It sits on the same open-drain SDA/SCL pins as the master in loopback and sensor-model setups.

Parameters:
DEVICE_ADDRESS, 7'h3C, 7-bit target address the block acknowledges.
FILTER_LEN, 3, number of consecutive equal sysclk samples before a filtered SCL/SDA level changes; legal range 1-7.

Ports:
i_sysclk  in  1  system clock; single clock domain.
i_arst  in  1  asynchronous, active-high reset.
i_scl  in  1  SCL pin level.
o_scl_oe  out  1  1 = pull SCL low (used for stretching only).
i_sda  in  1  SDA pin level.
o_sda_oe  out  1  1 = pull SDA low (open-drain).
o_reg_addr  out  16  current register pointer.
o_reg_wdata  out  8  write data, valid while o_reg_we = 1.
o_reg_we  out  1  one-cycle write strobe.
o_reg_re  out  1  one-cycle read request at o_reg_addr.
i_reg_rdata  in  8  read data, sampled 1 sysclk after o_reg_re.
o_busy  out  1  1 between an addressed START and the next STOP.

Behaviour:
- Reset (async, active-high): all outputs 0; pointer = 16'h0000; FSM in IDLE.
- Line conditioning: 2-FF synchronizer on each pin, then a FILTER_LEN-sample debounce. Edge detects run on the filtered levels. All protocol decisions use filtered signals only.
- START = filtered SDA falls while SCL is high. STOP = filtered SDA rises while SCL is high. Both are recognised in any state and take priority over bit sampling in the same cycle.
- Bits are sampled on SCL rise. SDA is changed only in the cycle after an SCL fall.
- FSM states: IDLE, DEV, ACK_DEV, SUB_HI, ACK_HI, SUB_LO, ACK_LO, WDATA, ACK_W, RDATA, RACK, IGNORE.
- IDLE -START-> DEV. DEV shifts 8 bits.
  - Address match with W (bit 0 = 0): ACK, then SUB_HI.
  - Address match with R: ACK, pulse o_reg_re, latch i_reg_rdata, then RDATA.
  - Mismatch: no ACK; go to IGNORE.
- SUB_HI/SUB_LO load the pointer MSB-first, each ACKed. Then WDATA.
- WDATA, on the 8th bit: o_reg_wdata = byte, o_reg_we pulses 1 cycle at the current pointer. Drive ACK, then increment the pointer.
- RDATA shifts out the latched byte MSB-first (releases SDA for 1s). RACK samples the master's bit:
  - ACK: increment pointer, pulse o_reg_re, latch, next byte.
  - NACK: go to IGNORE.
- ACK drive: o_sda_oe = 1 from the SCL fall after bit 8 until the SCL fall after the ACK clock.
- Repeated START from any state goes to DEV and keeps the pointer. This supports write-address-then-read.
- STOP from any state goes to IDLE and releases SDA. A partially received byte is discarded with no o_reg_we.
- IGNORE releases both lines and waits for START/STOP.
- Pointer wraps 16'hFFFF -> 16'h0000.
- o_busy rises on the ACK_DEV entry and falls on STOP.
- Without stretching, i_reg_rdata must be valid 1 sysclk after o_reg_re. Minimum sysclk is 16x SCL.

Optional Feature:
SCCB_STRETCH_EN
- Defined: after each SCL fall that precedes a read byte, hold o_scl_oe = 1 until read data is latched, for 2 sysclk plus sync latency. This accommodates slower register sources.
- Undefined: o_scl_oe is constant 0 and the stretch logic is absent.

Decomposition:
- Package sccb_pkg: FSM state enum, START/STOP event encoding, ACK/NACK bit constants.
- Sub-module sccb_line_filter (instanced twice): synchronizer, debounce counter, and rise/fall pulses for one pin.
- The top holds the FSM, shift register, bit counter and pointer.

Test Plan:
1. Write 0x78, 0x30, 0x08, 0x82, STOP -> four ACKs; o_reg_we once with addr 16'h3008, data 8'h82; o_busy 1 -> 0.
2. Burst write at 0x3100 of A5, 5A, FF -> we at 3100/3101/3102 with those data; final pointer 16'h3103.
3. Write 0x78 30 0A, repeated START, 0x79, rdata model returns 0x56 -> SDA bits 0101_0110; master NACK -> IGNORE; no we pulses.
4. Address 0x7A -> no ACK (o_sda_oe stays 0), no re/we, o_busy 0 through STOP.
5. Pointer 0xFFFF with 2 write bytes -> we at FFFF then 0000.
6. STOP after 4 data bits, and separately async reset mid-byte -> no we; next transaction to 0x1234 works normally.
